// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM: registers the winning command, returns read data 2 cycles after grant.
// Define ARB_ROUND_ROBIN_EN for the owner FSM with MAX_BURST fairness; otherwise port 0 has fixed priority.
module sram_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  output logic          sram_we,
  input  logic [DW-1:0] sram_dout
);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("MAX_BURST must be in 1..15");
  end

`ifdef ARB_ROUND_ROBIN_EN
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  owner_e     owner_q, owner_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       last_gnt_q, last_gnt_d;
  logic       pick0, pick1;

  always_comb begin
    pick0       = 1'b0;
    pick1       = 1'b0;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    last_gnt_d  = last_gnt_q;
    case (owner_q)
      OWN0: begin
        if (req0 && (!req1 || burst_cnt_q < BURST_MAX)) pick0 = 1'b1;
        else if (req1)                                  pick1 = 1'b1;
      end
      OWN1: begin
        if (req1 && (!req0 || burst_cnt_q < BURST_MAX)) pick1 = 1'b1;
        else if (req0)                                  pick0 = 1'b1;
      end
      default: begin
        // A tie from idle goes to whichever port was not served last.
        if (req0 && req1) begin
          pick0 = last_gnt_q;
          pick1 = !last_gnt_q;
        end else begin
          pick0 = req0;
          pick1 = req1;
        end
      end
    endcase

    if (pick0) begin
      owner_d     = OWN0;
      last_gnt_d  = 1'b0;
      burst_cnt_d = (owner_q != OWN0) ? 4'd1 :
                    (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
    end else if (pick1) begin
      owner_d     = OWN1;
      last_gnt_d  = 1'b1;
      burst_cnt_d = (owner_q != OWN1) ? 4'd1 :
                    (burst_cnt_q < BURST_MAX) ? burst_cnt_q + 4'd1 : burst_cnt_q;
    end else begin
      owner_d     = IDLE;
      burst_cnt_d = 4'd0;
    end

    gnt0 = pick0 && !rst;
    gnt1 = pick1 && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= IDLE;
      burst_cnt_q <= 4'd0;
      last_gnt_q  <= 1'b1;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
    end
  end
`else
  always_comb begin
    gnt0 = req0 && !rst;
    gnt1 = req1 && !req0 && !rst;
  end
`endif

  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [DW-1:0] sram_din_q, sram_din_d;
  logic          sram_we_q, sram_we_d;
  logic [1:0]    rd0_pipe_q, rd0_pipe_d;
  logic [1:0]    rd1_pipe_q, rd1_pipe_d;

  always_comb begin
    sram_addr_d = sram_addr_q;
    sram_din_d  = sram_din_q;
    sram_we_d   = 1'b0;
    if (gnt0) begin
      sram_addr_d = addr0;
      sram_din_d  = wdata0;
      sram_we_d   = we0;
    end else if (gnt1) begin
      sram_addr_d = addr1;
      sram_din_d  = wdata1;
      sram_we_d   = we1;
    end
    // Stage 0: read accepted; stage 1: SRAM has sampled, data on sram_dout.
    rd0_pipe_d = {rd0_pipe_q[0], gnt0 && !we0};
    rd1_pipe_d = {rd1_pipe_q[0], gnt1 && !we1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_addr_q <= '0;
      sram_din_q  <= '0;
      sram_we_q   <= 1'b0;
      rd0_pipe_q  <= '0;
      rd1_pipe_q  <= '0;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_din_q  <= sram_din_d;
      sram_we_q   <= sram_we_d;
      rd0_pipe_q  <= rd0_pipe_d;
      rd1_pipe_q  <= rd1_pipe_d;
    end
  end

  assign sram_addr = sram_addr_q;
  assign sram_din  = sram_din_q;
  assign sram_we   = sram_we_q;
  assign rvalid0   = rd0_pipe_q[1];
  assign rvalid1   = rd1_pipe_q[1];
  assign rdata0    = sram_dout;
  assign rdata1    = sram_dout;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single-port 4K x 16 SRAM between two requesters: port 0 is the CPU, port 1 is a loader/DMA engine.
- Sits between the requesters and the SRAM instance in the computer top level, and owns the SRAM's addr/din/we inputs.
- Accepts at most one access per cycle, registers the winning command into the SRAM, and routes read data back to the issuing port with a fixed latency.

Parameters:
- AW, 12, address width (SRAM depth 2^AW words)
- DW, 16, data width
- MAX_BURST, 4, consecutive grants one port may hold while the other is waiting (round-robin build only; range 1..15)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  port 0 (CPU) access request
- we0  input  1  port 0 write enable (1 = write, 0 = read)
- addr0  input  AW  port 0 address
- wdata0  input  DW  port 0 write data
- gnt0  output  1  port 0 request accepted this cycle
- rvalid0  output  1  port 0 read data valid
- rdata0  output  DW  port 0 read data
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1 (loader/DMA)
- sram_addr  output  AW  SRAM address (registered)
- sram_din  output  DW  SRAM write data (registered)
- sram_we  output  1  SRAM write enable (registered)
- sram_dout  input  DW  SRAM read data, valid the cycle after the SRAM samples addr

Behaviour:
- Reset: rst is synchronous and active-high, sampled on the rising edge of clk.
  - Reset values: sram_addr=0, sram_din=0, sram_we=0, rvalid0=rvalid1=0, owner=IDLE, burst_cnt=0, last_gnt=1 (so port 0 wins the first tie).
  - gnt0/gnt1 are forced to 0 while rst=1.
- Grant:
  - gntN is combinational in the cycle reqN is high and port N wins; the access is accepted at that clock edge.
  - gnt0 and gnt1 are never both 1.
  - A requester holds reqN, weN, addrN and wdataN stable until it sees gntN.
  - The next cycle the requester may present a new request, or drop reqN.
  - Throughput: one access per cycle, with no bubbles between back-to-back grants.
- Command: at a granting edge, sram_addr/sram_din/sram_we load the winner's addr/wdata/we.
  - Cycles with no grant load sram_we=0; addr and din hold their previous values.
  - A write is therefore a one-cycle sram_we pulse.
- Read latency: request accepted at edge E0; SRAM samples at E1; rvalidN=1 during the cycle after E1, i.e. 2 cycles after the cycle gntN was high.
  - rdataN = sram_dout, qualified by rvalidN.
  - rvalidN is a 2-stage pipeline per port, tagged by grant port and read.
  - A write never produces rvalid.
- Owner FSM (round-robin build): states IDLE, OWN0, OWN1.
  - IDLE: single request -> grant it, go to OWNn, burst_cnt=1. Both requests -> grant the port != last_gnt.
  - OWNn with reqn only: keep granting n; burst_cnt saturates at MAX_BURST.
  - OWNn with other port only: switch to the other port, burst_cnt=1.
  - OWNn with both requesting: grant n while burst_cnt<MAX_BURST, else grant the other port, switch owner, burst_cnt=1.
  - No requests -> IDLE, burst_cnt=0; last_gnt keeps the last granted port.
- Boundaries:
  - Address wraps naturally at 2^AW-1 (no arbiter-side checking).
  - rst asserted mid-read flushes the rvalid pipeline; no rvalid is produced after reset even if a read was in flight.
  - reqN deasserted without a grant is legal and leaves no state behind.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: the owner FSM and MAX_BURST fairness operate as described above.
- Not defined: strict fixed priority. Port 0 wins whenever req0=1; port 1 is granted only when req0=0. burst_cnt and owner logic are not built; last_gnt is unused. Port 1 may starve.

Test Plan:
- Reset, then port 0 writes 0xBEEF @0x005 -> gnt0=1 that cycle; next cycle sram_we=1, sram_addr=0x005, sram_din=0xBEEF; rvalid0 stays 0.
- Port 0 reads @0x005 after that write -> gnt0 in cycle k, rvalid0=1 in cycle k+2, rdata0=0xBEEF; rvalid1=0 throughout.
- Port 1 issues back-to-back reads @0x000..0x003 with port 0 idle -> gnt1 in 4 consecutive cycles; rvalid1 in 4 consecutive cycles with data in address order.
- Round-robin build, both ports request continuously, MAX_BURST=4, first cycle after reset -> port 0 granted 4 cycles, then port 1 4 cycles, alternating; never both gnt high.
- Fixed-priority build, same stimulus -> gnt0 every cycle and gnt1=0; drop req0 -> gnt1=1 the same cycle.
- Port 1 read granted, rst asserted the next cycle -> rvalid1 never asserts; all outputs at their reset values on the cycle after the reset edge.
